// File: rtl/cfu_l2_initiator.sv
// cfu_l2_initiator: initiator (requester) end of the CFU-L2 request/response link.
//
// Host commands arrive on a valid/ready command channel and are registered into a
// single-entry request stage that drives the L2 request channel. L2 responses are
// always accepted (resp_ready follows clk_en) into an in-order response FIFO whose head
// is registered onto the host response channel. A credit counter (inflight) bounds the
// accepted-but-not-returned commands to MAX_OUTSTANDING. That bound guarantees FIFO space,
// so the responder is never back-pressured.
//
// Ports:
//   clk, rst_n, clk_en           clock, async active-low reset, clock enable (low freezes)
//   cmd_*                        host command channel (valid/ready, cfu/func id, 2 operands)
//   req_*                        L2 request channel (valid/ready, cfu/func id, 2 operands)
//   resp_*                       L2 response channel (valid/ready, 3-bit status, data)
//   rsp_*                        host response channel (valid/ready, status, data)
//   inflight                     credits in use
//   timeout                      sticky watchdog error
//
// Optional feature macro: CFU_L2_INITIATOR_TIMEOUT_EN. When it is defined, a watchdog
// flags requests left unanswered for TIMEOUT_CYCLES cycles. Otherwise timeout is tied to 0.
module cfu_l2_initiator #(
  parameter int unsigned CFU_CFU_ID_W    = 1,
  parameter int unsigned CFU_FUNC_ID_W   = 10,
  parameter int unsigned CFU_DATA_W      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clk_en,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic [CFU_CFU_ID_W-1:0]                  cmd_cfu,
  input  logic [CFU_FUNC_ID_W-1:0]                 cmd_func,
  input  logic [CFU_DATA_W-1:0]                    cmd_data0,
  input  logic [CFU_DATA_W-1:0]                    cmd_data1,
  output logic                                     req_valid,
  input  logic                                     req_ready,
  output logic [CFU_CFU_ID_W-1:0]                  req_cfu,
  output logic [CFU_FUNC_ID_W-1:0]                 req_func,
  output logic [CFU_DATA_W-1:0]                    req_data0,
  output logic [CFU_DATA_W-1:0]                    req_data1,
  input  logic                                     resp_valid,
  output logic                                     resp_ready,
  input  logic [2:0]                               resp_status,
  input  logic [CFU_DATA_W-1:0]                    resp_data,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [2:0]                               rsp_status,
  output logic [CFU_DATA_W-1:0]                    rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     inflight,
  output logic                                     timeout
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned EntW = 3 + CFU_DATA_W;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Request stage
  logic                     req_valid_q, req_valid_d;
  logic [CFU_CFU_ID_W-1:0]  req_cfu_q, req_cfu_d;
  logic [CFU_FUNC_ID_W-1:0] req_func_q, req_func_d;
  logic [CFU_DATA_W-1:0]    req_data0_q, req_data0_d;
  logic [CFU_DATA_W-1:0]    req_data1_q, req_data1_d;

  // Credits
  logic [CntW-1:0] inflight_q, inflight_d;

  // Response FIFO storage plus registered head
  logic [EntW-1:0]       mem_q [MAX_OUTSTANDING];
  logic [EntW-1:0]       mem_d [MAX_OUTSTANDING];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [2:0]            rsp_status_q, rsp_status_d;
  logic [CFU_DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic cmd_hs, req_hs, resp_hs, rsp_hs;
  logic head_free, fifo_empty, push_mem, pop_mem;

  assign cmd_ready  = rst_n && clk_en && (inflight_q < MaxCnt) && (!req_valid_q || req_ready);
  assign resp_ready = rst_n && clk_en;

  assign cmd_hs  = cmd_valid && cmd_ready;
  assign req_hs  = clk_en && req_valid_q && req_ready;
  assign resp_hs = resp_valid && resp_ready;
  assign rsp_hs  = clk_en && rsp_valid_q && rsp_ready;

  // The head can take a new entry when empty or being popped this cycle.
  assign head_free  = clk_en && (!rsp_valid_q || rsp_hs);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop_mem    = head_free && !fifo_empty;
  // With empty storage and a free head, a response is registered straight into the head.
  assign push_mem   = resp_hs && !(head_free && fifo_empty);

  always_comb begin
    req_valid_d = req_valid_q;
    req_cfu_d   = req_cfu_q;
    req_func_d  = req_func_q;
    req_data0_d = req_data0_q;
    req_data1_d = req_data1_q;
    if (cmd_hs) begin
      req_valid_d = 1'b1;
      req_cfu_d   = cmd_cfu;
      req_func_d  = cmd_func;
      req_data0_d = cmd_data0;
      req_data1_d = cmd_data1;
    end else if (req_hs) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({cmd_hs, rsp_hs})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_mem) begin
      mem_d[wptr_q] = {resp_status, resp_data};
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_mem) begin
      rptr_d = ptr_inc(rptr_q);
    end
    unique case ({push_mem, pop_mem})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    if (head_free) begin
      if (!fifo_empty) begin
        rsp_valid_d                = 1'b1;
        {rsp_status_d, rsp_data_d} = mem_q[rptr_q];
      end else if (resp_hs) begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = resp_status;
        rsp_data_d   = resp_data;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q  <= 1'b0;
      req_cfu_q    <= '0;
      req_func_q   <= '0;
      req_data0_q  <= '0;
      req_data1_q  <= '0;
      inflight_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      req_valid_q  <= req_valid_d;
      req_cfu_q    <= req_cfu_d;
      req_func_q   <= req_func_d;
      req_data0_q  <= req_data0_d;
      req_data1_q  <= req_data1_d;
      inflight_q   <= inflight_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      mem_q        <= mem_d;
    end
  end

  // Credits make an overflowing push impossible; firing means the accounting is broken.
  push_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_mem && (fifo_cnt_q == MaxCnt) && !pop_mem));

  assign req_valid  = req_valid_q;
  assign req_cfu    = req_cfu_q;
  assign req_func   = req_func_q;
  assign req_data0  = req_data0_q;
  assign req_data1  = req_data1_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data   = rsp_data_q;
  assign inflight   = inflight_q;

`ifdef CFU_L2_INITIATOR_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES);

  logic [ToW-1:0] wd_cnt_q, wd_cnt_d;
  logic           timeout_q, timeout_d;
  logic [CntW:0]  held;
  logic           waiting;

  // Credits not accounted for by the request stage, the FIFO or the head are at the
  // responder, i.e. issued but unanswered.
  always_comb begin
    held      = {1'b0, fifo_cnt_q} + (CntW+1)'(rsp_valid_q) + (CntW+1)'(req_valid_q);
    waiting   = {1'b0, inflight_q} > held;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (clk_en) begin
      if (resp_hs || !waiting) begin
        wd_cnt_d = '0;
      end else begin
        if (wd_cnt_q != ToMax) begin
          wd_cnt_d = wd_cnt_q + ToW'(1);
        end
        if (32'(wd_cnt_q) + 32'd1 >= TIMEOUT_CYCLES) begin
          timeout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cfu_l2_initiator.sv
// Self-checking bench for cfu_l2_initiator. The bench plays host and L2 responder.
// The responder answers each request with status = func[2:0] ^ 3 and data = data0 + data1
// after a programmable latency. Expected host responses follow from the same rule,
// applied to the commands the host issued, in issue order.
module tb_cfu_l2_initiator;

`ifdef CFU_L2_INITIATOR_TIMEOUT_EN
  localparam int unsigned TbTo = 16;
`else
  localparam int unsigned TbTo = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_cfu = '0;
  logic [9:0]  cmd_func = '0;
  logic [31:0] cmd_data0 = '0, cmd_data1 = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [0:0]  req_cfu;
  logic [9:0]  req_func;
  logic [31:0] req_data0, req_data1;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [2:0]  resp_status = '0;
  logic [31:0] resp_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_data;
  logic [2:0]  inflight;
  logic        timeout;

  cfu_l2_initiator #(
    .CFU_CFU_ID_W   (1),
    .CFU_FUNC_ID_W  (10),
    .CFU_DATA_W     (32),
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES (TbTo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_cfu    (cmd_cfu),
    .cmd_func   (cmd_func),
    .cmd_data0  (cmd_data0),
    .cmd_data1  (cmd_data1),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cfu    (req_cfu),
    .req_func   (req_func),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_status(resp_status),
    .resp_data  (resp_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_data   (rsp_data),
    .inflight   (inflight),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [0:0] cfu; logic [9:0] func; logic [31:0] d0; logic [31:0] d1;} cmd_t;
  typedef struct packed {logic [2:0] st; logic [31:0] d;} rsp_t;
  typedef struct packed {logic [31:0] due; logic [2:0] st; logic [31:0] d;} pend_t;

  cmd_t  req_exp_q[$];
  rsp_t  rsp_exp_q[$];
  pend_t pend_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    inflight_m = 0;
  int    n_reqhs = 0;
  int    first_acc = -1;
  int    last_acc = -1;
  int    lat_mode = 1;
  bit    resp_en = 1'b1;
  bit    cmd_acc;

  function automatic rsp_t l2_rule(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.st = f[2:0] ^ 3'd3;
    r.d  = a + b;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s observed=event expected=none", tag);
  endtask

  function automatic logic [127:0] snap();
    return {req_valid, req_cfu, req_func, req_data0, req_data1, rsp_valid, rsp_status, rsp_data,
            inflight};
  endfunction

  task automatic new_cmd();
    cmd_cfu   = 1'($urandom);
    cmd_func  = 10'($urandom);
    cmd_data0 = $urandom;
    cmd_data1 = $urandom;
  endtask

  // One clock cycle: responder drive, handshake bookkeeping, edge, credit check.
  task automatic tick();
    bit c_hs, q_hs, r_hs, h_hs;
    int lat;
    if (resp_en && pend_q.size() > 0 && pend_q[0].due <= 32'(cyc)) begin
      resp_valid  = 1'b1;
      resp_status = pend_q[0].st;
      resp_data   = pend_q[0].d;
    end else begin
      resp_valid  = 1'b0;
      resp_status = 3'($urandom);
      resp_data   = $urandom;
    end
    #1;
    c_hs = cmd_valid && cmd_ready;
    q_hs = clk_en && req_valid && req_ready;
    r_hs = resp_valid && resp_ready;
    h_hs = clk_en && rsp_valid && rsp_ready;
    cmd_acc = c_hs;
    if (c_hs) begin
      req_exp_q.push_back({cmd_cfu, cmd_func, cmd_data0, cmd_data1});
      rsp_exp_q.push_back(l2_rule(cmd_func, cmd_data0, cmd_data1));
      inflight_m++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (q_hs) begin
      n_reqhs++;
      if (req_exp_q.size() == 0) begin
        fail("req_spurious");
      end else begin
        check("req_fields", {req_cfu, req_func, req_data0, req_data1}, req_exp_q[0]);
        void'(req_exp_q.pop_front());
      end
      lat = (lat_mode == 0) ? int'($urandom_range(3, 1)) : lat_mode;
      pend_q.push_back({32'(cyc + lat), l2_rule(req_func, req_data0, req_data1)});
    end
    if (r_hs) void'(pend_q.pop_front());
    if (h_hs) begin
      if (rsp_exp_q.size() == 0) begin
        fail("rsp_spurious");
      end else begin
        check("rsp_order", {rsp_status, rsp_data}, rsp_exp_q[0]);
        void'(rsp_exp_q.pop_front());
      end
      inflight_m--;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("inflight", inflight, inflight_m);
    check("inflight_le_max", inflight <= 3'd4, 1'b1);
  endtask

  // Random stream of n commands, drained to empty; optional 3-cycle clk_en freeze.
  task automatic run(input int n, input int unsigned p_req, input int unsigned p_rsp,
                     input int lm, input int freeze_at);
    int acc;
    int k;
    bit frz;
    logic [127:0] sv;
    acc = 0;
    k = 0;
    sv = '0;
    lat_mode = lm;
    while ((acc < n || inflight_m > 0) && k < 3000) begin
      if (!cmd_valid && acc < n) begin
        new_cmd();
        cmd_valid = 1'b1;
      end
      req_ready = ($urandom_range(99, 0) < p_req);
      rsp_ready = ($urandom_range(99, 0) < p_rsp);
      frz = (freeze_at >= 0) && (k >= freeze_at) && (k < freeze_at + 3);
      clk_en = !frz;
      if (frz && k == freeze_at) sv = snap();
      if (frz) begin
        #1;
        check("frz_cmd_ready", cmd_ready, 1'b0);
        check("frz_resp_ready", resp_ready, 1'b0);
        check("frz_hold", snap(), sv);
      end
      tick();
      if (frz) check("frz_hold_edge", snap(), sv);
      if (cmd_acc) begin
        cmd_valid = 1'b0;
        acc++;
      end
      k++;
    end
    if (k >= 3000) fail("run_budget");
    clk_en    = 1'b1;
    req_ready = 1'b1;
    rsp_ready = 1'b1;
    check("run_req_q_empty", req_exp_q.size(), 0);
    check("run_rsp_q_empty", rsp_exp_q.size(), 0);
  endtask

  initial begin
    cmd_t held_cmd;
    int   n0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_resp_ready", resp_ready, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_fields", {req_cfu, req_func, req_data0, req_data1}, 0);
    check("rst_rsp", {rsp_valid, rsp_status, rsp_data}, 0);
    check("rst_inflight", inflight, 0);
    check("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;

    // Single command: func=3, 5+7, responder latency 1
    lat_mode = 1;
    cmd_cfu = '0; cmd_func = 10'd3; cmd_data0 = 32'd5; cmd_data1 = 32'd7;
    cmd_valid = 1'b1;
    #1;
    check("t1_cmd_ready", cmd_ready, 1'b1);
    check("t1_resp_ready", resp_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("t1_req_valid", req_valid, 1'b1);
    check("t1_req_fields", {req_func, req_data0, req_data1}, {10'd3, 32'd5, 32'd7});
    check("t1_rsp_idle", rsp_valid, 1'b0);
    tick();
    check("t1_req_drop", req_valid, 1'b0);
    check("t1_rsp_not_early", rsp_valid, 1'b0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_status", rsp_status, 3'd0);
    check("t1_rsp_data", rsp_data, 32'd12);
    tick();
    check("t1_rsp_done", rsp_valid, 1'b0);
    check("t1_inflight0", inflight, 0);

    // Back-to-back throughput: 8 commands over 8 consecutive cycles
    first_acc = -1;
    run(8, 100, 100, 1, -1);
    check("t2_b2b_span", last_acc - first_acc, 7);

    // Host back-pressure fills all credits
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      new_cmd();
      cmd_valid = 1'b1;
      #1;
      check("t3_accept", cmd_ready, 1'b1);
      tick();
    end
    new_cmd();
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t3_cmd_blocked", cmd_ready, 1'b0);
      check("t3_resp_ready", resp_ready, 1'b1);
      tick();
    end
    check("t3_full_credits", inflight, 4);
    rsp_ready = 1'b1;
    #1;
    check("t3_still_blocked", cmd_ready, 1'b0);
    tick();
    #1;
    check("t3_reassert", cmd_ready, 1'b1);
    tick();
    check("t3_fifth_taken", cmd_acc, 1'b1);
    cmd_valid = 1'b0;
    run(0, 100, 100, 1, -1);

    // L2 request back-pressure
    req_ready = 1'b0;
    new_cmd();
    held_cmd = {cmd_cfu, cmd_func, cmd_data0, cmd_data1};
    cmd_valid = 1'b1;
    tick();
    new_cmd();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_cmd_blocked", cmd_ready, 1'b0);
      check("t4_req_valid", req_valid, 1'b1);
      check("t4_req_stable", {req_cfu, req_func, req_data0, req_data1}, held_cmd);
      tick();
    end
    n0 = n_reqhs;
    req_ready = 1'b1;
    #1;
    check("t4_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    req_ready = 1'b0;
    check("t4_one_hs", n_reqhs - n0, 1);
    check("t4_next_req", req_valid, 1'b1);
    tick();
    check("t4_still_one_hs", n_reqhs - n0, 1);
    req_ready = 1'b1;
    run(0, 100, 100, 1, -1);

    // clk_en freeze mid-stream, then a random stream with random latency
    run(12, 100, 100, 1, 5);
    run(40, 70, 60, 0, 17);
    check("timeout_low", timeout, 1'b0);

    // Asynchronous reset mid-transfer
    lat_mode = 1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!cmd_valid) begin
        new_cmd();
        cmd_valid = 1'b1;
      end
      tick();
      if (cmd_acc) cmd_valid = 1'b0;
    end
    check("t5_busy", inflight != 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_req", {req_valid, req_cfu, req_func, req_data0, req_data1}, 0);
    check("t5_rst_rsp", {rsp_valid, rsp_status, rsp_data}, 0);
    check("t5_rst_inflight", inflight, 0);
    check("t5_rst_ready", {cmd_ready, resp_ready}, 0);
    check("t5_rst_timeout", timeout, 1'b0);
    cmd_valid = 1'b0;
    resp_valid = 1'b0;
    rsp_ready = 1'b1;
    req_exp_q.delete();
    rsp_exp_q.delete();
    pend_q.delete();
    inflight_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(6, 100, 100, 1, -1);

`ifdef CFU_L2_INITIATOR_TIMEOUT_EN
    // Unanswered request trips the watchdog 16 cycles after its handshake
    resp_en = 1'b0;
    new_cmd();
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", timeout, 1'b0);
    tick();
    check("to_set", timeout, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("to_sticky", timeout, 1'b1);
    rst_n = 1'b0;
    #1;
    check("to_rst_clear", timeout, 1'b0);
    req_exp_q.delete();
    rsp_exp_q.delete();
    pend_q.delete();
    inflight_m = 0;
    resp_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
`else
    check("timeout_tied", timeout, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfu_l2_initiator.md
Name: cfu_l2_initiator

Overview:
- CFU-L2 requester: the initiator end of the L2 request/response interface, the counterpart to L2 responder CFUs and adapters.
- Accepts host commands on a simple valid/ready command channel and issues them as L2 requests.
- Collects in-order L2 responses into a response FIFO and returns them to the host on a valid/ready channel.
- Credit accounting guarantees response space, so the block never back-pressures a responder. Used as a CPU-side shim and as a bench driver for zoo CFUs.

Parameters:
- CFU_CFU_ID_W, 1, width of CFU id field
- CFU_FUNC_ID_W, 10, width of function id field
- CFU_DATA_W, 32, request/response data width
- MAX_OUTSTANDING, 4, max commands accepted but not yet returned to host (>=1); also the response FIFO depth
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clk_en  input  1  clock enable; low freezes all state
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  host command accepted
- cmd_cfu  input  CFU_CFU_ID_W  target CFU id
- cmd_func  input  CFU_FUNC_ID_W  function id
- cmd_data0  input  CFU_DATA_W  operand 0
- cmd_data1  input  CFU_DATA_W  operand 1
- req_valid  output  1  L2 request valid
- req_ready  input  1  L2 request ready
- req_cfu  output  CFU_CFU_ID_W  L2 request CFU id
- req_func  output  CFU_FUNC_ID_W  L2 request function id
- req_data0  output  CFU_DATA_W  L2 request operand 0
- req_data1  output  CFU_DATA_W  L2 request operand 1
- resp_valid  input  1  L2 response valid
- resp_ready  output  1  L2 response ready
- resp_status  input  3  L2 response status (CFU_OK=0)
- resp_data  input  CFU_DATA_W  L2 response data
- rsp_valid  output  1  host response valid
- rsp_ready  input  1  host response ready
- rsp_status  output  3  host response status
- rsp_data  output  CFU_DATA_W  host response data
- inflight  output  $clog2(MAX_OUTSTANDING+1)  credits in use
- timeout  output  1  sticky watchdog error (0 unless feature enabled)

Behaviour:
- Async reset (rst_n low): req_valid=0, req_* data/id=0, rsp_valid=0, rsp_status=0, rsp_data=0, inflight=0, timeout=0, FIFO empty. cmd_ready and resp_ready are 0 during reset. Any in-progress transaction is discarded.
- All handshakes count only when clk_en=1. When clk_en=0: cmd_ready=0, resp_ready=0, registers hold, outputs stable.
- Credits: one credit is taken on cmd handshake and released on rsp handshake. Same-cycle take and release leaves inflight unchanged. inflight never exceeds MAX_OUTSTANDING and never underflows.
- Request stage (single register):
  - cmd_ready = clk_en && inflight<MAX_OUTSTANDING && (!req_valid || req_ready).
  - A command accepted in cycle t drives req_valid=1 with its fields in t+1.
  - req_* holds stable while req_valid && !req_ready.
  - req_valid drops after handshake unless a new command is accepted the same cycle (back-to-back, one per cycle).
- resp_ready = clk_en && rst_n, i.e. constant 1 in operation. Credits guarantee FIFO space.
- A resp handshake pushes {status,data} into the FIFO. A push while full is a design error (assertion).
- Response FIFO: depth MAX_OUTSTANDING, in-order, with head registered onto rsp_*. No bypass: a response handshaken in cycle t gives rsp_valid=1 in t+1 at the earliest.
- Simultaneous FIFO push and pop is supported, including at full and at empty-with-head. Read/write pointers wrap modulo MAX_OUTSTANDING.
- rsp_* holds stable while rsp_valid && !rsp_ready.
- Status values pass through unmodified; non-OK status is not interpreted.

Optional Feature:
CFU_L2_INITIATOR_TIMEOUT_EN:
- Defined: a watchdog counter runs while (inflight minus FIFO occupancy minus pending-request) > 0, i.e. requests are issued but unanswered, and resets on every resp handshake. Reaching TIMEOUT_CYCLES sets timeout=1 (sticky until rst_n); traffic continues unaffected.
- Undefined: no counter logic; timeout tied to 0.

Test Plan:
- Reset, then one command (func=3, data0=5, data1=7), responder replies 1 cycle after handshake with OK, data=12 -> req_valid in cycle after cmd handshake; rsp_valid 1 cycle after resp handshake with status=0, data=12; inflight returns to 0.
- 8 back-to-back commands, req_ready=1, responder latency 1, rsp_ready=1 -> steady state of one command per cycle; responses in order; inflight <= 4.
- rsp_ready=0, issue 4 commands -> 5th sees cmd_ready=0; resp_ready stays 1. Raise rsp_ready -> responses drain in order and cmd_ready reasserts the cycle after the first rsp handshake.
- req_ready=0 for 5 cycles with a pending request -> req_* stable, cmd_ready=0; on req_ready=1 exactly one request handshakes.
- clk_en=0 mid-stream for 3 cycles -> no handshakes, outputs frozen; afterwards the stream resumes with no loss or duplication. Assert rst_n low mid-transfer -> all outputs return to reset values immediately.
- With CFU_L2_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES=16, issue a request and never respond -> timeout=1 at 16 cycles after the req handshake and stays 1.
